// File: rtl/regfile_write_scheduler.sv
// Purpose : owns port A of the 64x16 register file; round-robin arbitration of two writers, zero-fill after reset/Clear.
// Latency : zero added cycles -- the register file is written on the same edge where Gnt0/Gnt1 is high.
// Backpr. : requesters hold Req/Addr/Data until granted; no grants while Busy (fill), a loser waits at most 1 cycle.
//
// Ports:
//   Clock, Reset (sync, active-high), Clear (pulse, restarts fill)
//   Req0/Addr0/Data0 -> Gnt0 : ALU writeback requester
//   Req1/Addr1/Data1 -> Gnt1 : load-unit requester
//   ReadAddrA                : read address passed to port A when no write occurs
//   RfAddressA/RfWriteData/RfWriteEnable : register file port A
//   Busy                     : zero-fill in progress
module regfile_write_scheduler #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 64
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Req0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] Data0,
  output logic              Gnt0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Data1,
  output logic              Gnt1,
  input  logic [ADDR_W-1:0] ReadAddrA,
  output logic [ADDR_W-1:0] RfAddressA,
  output logic [DATA_W-1:0] RfWriteData,
  output logic              RfWriteEnable,
  output logic              Busy
);

  typedef enum logic {
    CLEARING = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;
  logic            last_gnt_q, last_gnt_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= CLEARING;
      clr_cnt_q  <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    last_gnt_d    = last_gnt_q;
    Gnt0          = 1'b0;
    Gnt1          = 1'b0;
    RfWriteEnable = 1'b0;
    RfAddressA    = ReadAddrA;
    RfWriteData   = '0;
    Busy          = 1'b0;

    unique case (state_q)
      CLEARING: begin
        RfWriteEnable = 1'b1;
        RfAddressA    = clr_cnt_q[ADDR_W-1:0];
        Busy          = 1'b1;
        if (Clear) begin
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_ONE;
          if (clr_cnt_q == LAST_IDX) state_d = RUN;
        end
      end

      RUN: begin
        // Requester 1 wins when alone, or when both ask and 0 went last.
        Gnt1 = Req1 && (!Req0 || !last_gnt_q);
        Gnt0 = Req0 && !Gnt1;
        if (Gnt0) begin
          RfWriteEnable = 1'b1;
          RfAddressA    = Addr0;
          RfWriteData   = Data0;
          last_gnt_d    = 1'b0;
        end else if (Gnt1) begin
          RfWriteEnable = 1'b1;
          RfAddressA    = Addr1;
          RfWriteData   = Data1;
          last_gnt_d    = 1'b1;
        end
        // The grant above still lands this cycle; the fill starts next cycle.
        if (Clear) begin
          state_d   = CLEARING;
          clr_cnt_d = '0;
        end
      end

      default: begin
        state_d = CLEARING;
      end
    endcase
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns port A of the 64x16 register file.
- Shares the single write path between two write requesters (0: ALU writeback, 1: load unit) using round-robin arbitration.
- Zero-fills the whole register array after reset or on a Clear command. The register array itself has no reset.
- When no write is in progress, port A's address is passed through from the read-side address input.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 6, register address width.
- NUM_REGS, 64, number of registers cleared by the fill sequence; must be ≤ 2**ADDR_W.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Clear  in  1  single-cycle pulse; restarts the zero-fill sequence.
- Req0  in  1  requester 0 write request; held until Gnt0.
- Addr0  in  ADDR_W  requester 0 target register.
- Data0  in  DATA_W  requester 0 write data.
- Gnt0  out  1  requester 0 write accepted this cycle.
- Req1  in  1  requester 1 write request; held until Gnt1.
- Addr1  in  ADDR_W  requester 1 target register.
- Data1  in  DATA_W  requester 1 write data.
- Gnt1  out  1  requester 1 write accepted this cycle.
- ReadAddrA  in  ADDR_W  read address driven onto port A when no write occurs.
- RfAddressA  out  ADDR_W  to register file AddressA.
- RfWriteData  out  DATA_W  to register file WriteData.
- RfWriteEnable  out  1  to register file WriteEnable.
- Busy  out  1  zero-fill in progress.

Behaviour:
- State: one state register with values CLEARING and RUN, plus ClrCnt (ADDR_W+1 bits) and LastGnt (1 bit).
- Reset (any cycle, including mid-fill or mid-grant): next state CLEARING, ClrCnt=0, LastGnt=1.
- CLEARING outputs:
  - RfWriteEnable=1, RfAddressA=ClrCnt[ADDR_W-1:0], RfWriteData=0, Busy=1.
  - Gnt0=Gnt1=0; requests stall.
  - Each cycle ClrCnt increments.
  - On the cycle where ClrCnt==NUM_REGS-1, next state is RUN.
  - Fill takes exactly NUM_REGS cycles (64). Busy falls the cycle after the write to register 63.
- RUN arbitration (grants are combinational from the current Req and LastGnt):
  - Only Req0: Gnt0=1.
  - Only Req1: Gnt1=1.
  - Both requesting: grant the requester ≠ LastGnt.
  - Gnt0 and Gnt1 are never both 1.
  - On a grant: RfWriteEnable=1; RfAddressA and RfWriteData come from the granted requester; LastGnt updates to the granted index at the clock edge.
- RUN with no request: RfWriteEnable=0, RfAddressA=ReadAddrA, RfWriteData=0; LastGnt holds.
- Write latency: the register file is updated at the same clock edge where Gnt is high (zero added cycles).
- A losing requester keeps Req, Addr and Data stable and is granted the following cycle if it still requests. Worst-case wait is 1 cycle.
- Same-address conflict: both writes occur in grant order; the later grant's data persists. No merging.
- Clear pulse:
  - In RUN: the current-cycle arbitration still completes. Next state is CLEARING with ClrCnt=0, and LastGnt is unchanged.
  - In CLEARING: ClrCnt restarts at 0.
- Reset and Clear together: reset wins, with identical result (LastGnt=1).
- Port A read data is valid only while RfWriteEnable=0. Readers must sample ReadDataA only when Busy=0 and there is no grant.

Test Plan:
- Reset high 1 cycle, then low → Busy=1 for 64 cycles; RfAddressA steps 0..63 with RfWriteEnable=1 and RfWriteData=0; Gnt0=Gnt1=0 throughout; Busy=0 at cycle 65; every register reads 0x0000.
- After fill: Req0 alone, Addr0=5, Data0=0xABCD → Gnt0=1 in the same cycle; RfWriteEnable=1 and RfAddressA=5; register 5 reads 0xABCD on the next cycle.
- Req0 and Req1 held together for 4 cycles after reset (Addr0=1/0x1111, Addr1=2/0x2222) → grants alternate 0,1,0,1; never both high in a cycle.
- Both requesters target address 7 (Data0=0x0007, Data1=0x7000), LastGnt=0 → Gnt1 first, then Gnt0; register 7 ends as 0x0007.
- Clear pulsed while Req1 is asserted in RUN → Gnt1 completes that cycle; Busy=1 on the next cycle; RfAddressA restarts at 0; register written by Req1 reads 0 after the fill.
- Reset asserted at fill step 30 → the next cycle shows RfAddressA=0 and Busy=1; the full 64-cycle fill reruns.
